// File: rtl/dsp_mode_mem_bank_programmer.sv
// BL/WL programmer for a DSP tile's mode-bit latch bank: takes one row of bitline data per
// handshake, sets up bl, pulses the row's wordline, then holds bl before moving to the next row.
module dsp_mode_mem_bank_programmer #(
    parameter int NUM_BL       = 85,
    parameter int NUM_WL       = 85,
    parameter int PULSE_CYCLES = 2,
    localparam int IDX_W       = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_BL-1:0] row_data,
    input  logic              row_valid,
    output logic              row_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic [IDX_W-1:0]  row_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [NUM_BL-1:0] bl_n;
    logic [NUM_WL-1:0] wl_n;
    logic [IDX_W-1:0]  idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        bl_n    = bl;
        idx_n   = row_idx;
        cnt_n   = cnt;
        wl_n    = '0;

        if (abort) begin
            state_n = S_IDLE;
            bl_n    = '0;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n = S_LOAD;
                        idx_n   = '0;
                        bl_n    = '0;
                    end
                end
                S_LOAD: begin
                    if (row_valid && row_ready) begin
                        bl_n    = row_data;
                        state_n = S_SETUP;
                    end
                end
                S_SETUP: begin
                    state_n = S_PULSE;
                    cnt_n   = '0;
                end
                S_PULSE: begin
                    if (cnt == CNT_LAST) state_n = S_HOLD;
                    else                 cnt_n   = cnt + CNT_W'(1);
                end
                S_HOLD: begin
                    // bl stayed stable through HOLD; it drops as the row retires.
                    bl_n = '0;
                    if (row_idx == IDX_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = row_idx + IDX_W'(1);
                        state_n = S_LOAD;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Outputs are registered, so the wordline is decoded from the next state and row.
        for (int i = 0; i < NUM_WL; i++) begin
            wl_n[i] = (state_n == S_PULSE) && (idx_n == IDX_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bl        <= '0;
            wl        <= '0;
            row_idx   <= '0;
            row_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bl        <= bl_n;
            wl        <= wl_n;
            row_idx   <= idx_n;
            row_ready <= (state_n == S_LOAD);
            busy      <= (state_n == S_LOAD) || (state_n == S_SETUP) ||
                         (state_n == S_PULSE) || (state_n == S_HOLD);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_dsp_mode_mem_bank_programmer.sv
// Self-checking bench: directed sequence with randomized row data, checked against a
// row-order/pulse-count model and the documented per-row cycle timing.
module tb_dsp_mode_mem_bank_programmer;

    localparam int NUM_BL = 85;
    localparam int NUM_WL = 85;
    localparam int PC     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start, abort, row_valid, row_ready, busy, done;
    logic [NUM_BL-1:0] row_data, bl;
    logic [NUM_WL-1:0] wl;
    logic [6:0]        row_idx;

    logic              s_start, s_abort, s_valid, s_ready, s_busy, s_done;
    logic [NUM_BL-1:0] s_data, s_bl;
    logic [0:0]        s_wl, s_row_idx;

    dsp_mode_mem_bank_programmer #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .PULSE_CYCLES(PC)) u_dut (
        .prog_clk(clk), .pReset(rst), .start(start), .abort(abort),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .bl(bl), .wl(wl), .row_idx(row_idx), .busy(busy), .done(done)
    );

    dsp_mode_mem_bank_programmer #(.NUM_BL(NUM_BL), .NUM_WL(1), .PULSE_CYCLES(2)) u_one (
        .prog_clk(clk), .pReset(rst), .start(s_start), .abort(s_abort),
        .row_data(s_data), .row_valid(s_valid), .row_ready(s_ready),
        .bl(s_bl), .wl(s_wl), .row_idx(s_row_idx), .busy(s_busy), .done(s_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    int pulse_q[$];
    logic [NUM_BL-1:0] exp_data [NUM_WL];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_BL-1:0] rand_row(input int i);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {r[NUM_BL-1:7], 7'(i)};
    endfunction

    // Model view: wl is one-hot-or-zero, each pulse names the current row, and bl carries that row's data.
    always @(negedge clk) begin
        if (mon_en) begin
            int k;
            k = -1;
            check("wl_onehot0", 128'($countones(wl) <= 1), 128'(1));
            for (int i = 0; i < NUM_WL; i++) if (wl[i]) k = i;
            if (k >= 0) begin
                check("wl_vs_row_idx", 128'(row_idx), 128'(k));
                check("bl_during_pulse", 128'(bl), 128'(exp_data[k]));
                pulse_q.push_back(k);
            end
        end
    end

    // Called at a negedge; presents one row and returns at the negedge after it is accepted.
    task automatic send_row(input logic [NUM_BL-1:0] d);
        bit ok;
        ok = 1'b0;
        row_valid = 1'b1;
        row_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (row_ready) ok = 1'b1;
            @(negedge clk);
        end
        row_valid = 1'b0;
        if (!ok) check("row_ready_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int t0, t1, n;
        logic [NUM_BL-1:0] keep;
        logic [NUM_WL-1:0] oh;

        start = 0; abort = 0; row_valid = 0; row_data = '0;
        s_start = 0; s_abort = 0; s_valid = 0; s_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bl", 128'(bl), 128'(0));
        check("rst_wl", 128'(wl), 128'(0));
        check("rst_row_idx", 128'(row_idx), 128'(0));
        check("rst_row_ready", 128'(row_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single-row bank
        s_start = 1; @(negedge clk); s_start = 0;
        check("one_ready", 128'(s_ready), 128'(1));
        check("one_busy", 128'(s_busy), 128'(1));
        s_data = 85'h1_5555; s_valid = 1;
        @(negedge clk); s_valid = 0; s_data = '1;
        check("one_setup_bl", 128'(s_bl), 128'(85'h1_5555));
        check("one_setup_wl", 128'(s_wl), 128'(0));
        @(negedge clk);
        check("one_pulse1_wl", 128'(s_wl), 128'(1));
        @(negedge clk);
        check("one_pulse2_wl", 128'(s_wl), 128'(1));
        @(negedge clk);
        check("one_hold_wl", 128'(s_wl), 128'(0));
        check("one_hold_bl", 128'(s_bl), 128'(85'h1_5555));
        check("one_hold_done", 128'(s_done), 128'(0));
        @(negedge clk);
        check("one_done", 128'(s_done), 128'(1));
        check("one_done_bl", 128'(s_bl), 128'(0));
        check("one_done_busy", 128'(s_busy), 128'(0));
        check("one_done_idx", 128'(s_row_idx), 128'(0));

        // Full pass, back-to-back rows
        for (int i = 0; i < NUM_WL; i++) exp_data[i] = rand_row(i);
        pulse_q.delete();
        mon_en = 1'b1;
        start = 1; t0 = cyc; @(negedge clk); start = 0;
        for (int i = 0; i < NUM_WL; i++) send_row(exp_data[i]);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        t1 = cyc;
        mon_en = 1'b0;
        check("pass_cycles", 128'(t1 - t0), 128'(1 + NUM_WL * (PC + 3)));
        check("pulse_count", 128'(pulse_q.size()), 128'(NUM_WL * PC));
        for (int j = 0; j < NUM_WL * PC && j < pulse_q.size(); j++)
            check("pulse_order", 128'(pulse_q[j]), 128'(j / PC));
        check("pass_done", 128'(done), 128'(1));
        check("pass_done_bl", 128'(bl), 128'(0));
        check("pass_done_idx", 128'(row_idx), 128'(NUM_WL - 1));
        repeat (3) @(negedge clk);
        check("no_rollover_idx", 128'(row_idx), 128'(NUM_WL - 1));
        check("no_rollover_done", 128'(done), 128'(1));

        // Backpressure; valid outside LOAD ignored
        start = 1; @(negedge clk); start = 0;
        check("restart_done_clr", 128'(done), 128'(0));
        check("restart_idx", 128'(row_idx), 128'(0));
        keep = rand_row(0);
        send_row(keep);
        row_valid = 1; row_data = ~keep;
        @(negedge clk);
        check("ign_valid_pulse_bl", 128'(bl), 128'(keep));
        @(negedge clk);
        @(negedge clk);
        check("ign_valid_hold_bl", 128'(bl), 128'(keep));
        row_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready", 128'(row_ready), 128'(1));
            check("bp_wl", 128'(wl), 128'(0));
            check("bp_idx", 128'(row_idx), 128'(1));
            check("bp_bl", 128'(bl), 128'(0));
        end

        // Abort on row 3 mid-pulse
        for (int i = 1; i <= 3; i++) send_row(rand_row(i));
        @(negedge clk);
        oh = '0; oh[3] = 1'b1;
        check("row3_pulse", 128'(wl), 128'(oh));
        abort = 1; @(negedge clk); abort = 0;
        check("abort_wl", 128'(wl), 128'(0));
        check("abort_idx", 128'(row_idx), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_bl", 128'(bl), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 128'(busy), 128'(0));
        start = 1; @(negedge clk); start = 0;
        check("after_abort_ready", 128'(row_ready), 128'(1));
        check("after_abort_idx", 128'(row_idx), 128'(0));
        send_row(rand_row(0));
        @(negedge clk);
        check("after_abort_wl0", 128'(wl), 128'(1));

        // start while busy; start+abort together
        start = 1; @(negedge clk); start = 0;
        check("busy_start_ready", 128'(row_ready), 128'(0));
        check("busy_start_wl", 128'(wl), 128'(1));
        start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
        check("sa_busy_busy", 128'(busy), 128'(0));
        check("sa_busy_wl", 128'(wl), 128'(0));
        start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
        check("sa_idle_ready", 128'(row_ready), 128'(0));
        check("sa_idle_busy", 128'(busy), 128'(0));

        // Async reset mid-pulse
        start = 1; @(negedge clk); start = 0;
        send_row(rand_row(0));
        @(negedge clk);
        check("pre_rst_wl", 128'(wl), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_wl", 128'(wl), 128'(0));
        check("async_rst_bl", 128'(bl), 128'(0));
        check("async_rst_done", 128'(done), 128'(0));
        check("async_rst_busy", 128'(busy), 128'(0));
        check("async_rst_idx", 128'(row_idx), 128'(0));
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 128'(busy), 128'(0));
        check("post_rst_ready", 128'(row_ready), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
